// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction layout, opcode values and the fetch
// state encoding used by the instruction fetch datapath.
//   INSTR_BYTES          bytes per instruction
//   OPC_LSB/OPA_LSB/OPB_LSB  bit positions of opcode / operand A / operand B
//   fetch_state_t        fetch sequencer states
//   cnt_width()          width of a counter that indexes 0..n-1 (minimum 1 bit)
package cpu_pkg;

    localparam int unsigned INSTR_BYTES = 3;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPA_LSB = 8;
    localparam int unsigned OPB_LSB = 16;

    localparam logic [7:0] STR_IMM = 8'h01;
    localparam logic [7:0] LOA_IMM = 8'h02;
    localparam logic [7:0] ADD     = 8'h03;
    localparam logic [7:0] SUB     = 8'h04;
    localparam logic [7:0] JMP     = 8'h05;
    localparam logic [7:0] HLT     = 8'hFF;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_DONE = 2'd3
    } fetch_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_ir_assembler.sv
// ir_assembler: collects instruction bytes into a shadow register and commits
// the whole instruction word to the IR in a single edge.
//   clk, rst      clock / synchronous active-high reset
//   start         clear the byte counter at the start of a fetch
//   capture       byte_in is valid; store it at byte position cnt
//   commit        copy shadow to command_word, pulse ir_valid next cycle
//   byte_in       instruction byte from program memory
//   cnt           index of the byte currently being fetched
//   last          cnt addresses the final byte of the instruction
//   command_word  instruction register (byte 0 in the low bits)
//   ir_valid      one-cycle pulse coincident with a new command_word
module ir_assembler
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned INSTR_BYTES = cpu_pkg::INSTR_BYTES,
    localparam int unsigned CNT_W      = cnt_width(INSTR_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          capture,
    input  logic                          commit,
    input  logic [DATA_W-1:0]             byte_in,
    output logic [CNT_W-1:0]              cnt,
    output logic                          last,
    output logic [INSTR_BYTES*DATA_W-1:0] command_word,
    output logic                          ir_valid
);

    logic [INSTR_BYTES*DATA_W-1:0] shadow;

    assign last = (cnt == CNT_W'(INSTR_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shadow       <= '0;
            command_word <= '0;
            ir_valid     <= 1'b0;
        end else begin
            ir_valid <= commit;

            if (start) begin
                cnt <= '0;
            end else if (capture && !last) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture) begin
                for (int unsigned i = 0; i < INSTR_BYTES; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        shadow[i*DATA_W +: DATA_W] <= byte_in;
                    end
                end
            end

            // IR only changes here, so it never shows a partly fetched instruction.
            if (commit) begin
                command_word <= shadow;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: datapath side of instruction fetch. Owns PC, MAR and IR,
// reads an instruction byte-by-byte from program memory when the control unit
// asks for it and presents the assembled command_word.
//   clk, rst      clock / synchronous active-high reset
//   pc_load       PC <= pc_load_val (wins over pc_inc)
//   pc_load_val   jump target
//   pc_inc        PC <= PC + INSTR_BYTES
//   mar_load      MAR <= PC (value before this cycle's PC update)
//   ir_load       start a fetch at MAR (ignored while busy)
//   mem_rd        one-cycle read request
//   mem_addr      read address, valid with mem_rd
//   mem_rdata     read data, valid with mem_rvalid
//   mem_rvalid    read response
//   command_word  IR: [7:0] opcode, [15:8] operand A, [23:16] operand B
//   ir_valid      one-cycle pulse when command_word has just been updated
//   busy          fetch in progress
//   pc            current program counter
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       INSTR_BYTES = cpu_pkg::INSTR_BYTES,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pc_load,
    input  logic [ADDR_W-1:0]             pc_load_val,
    input  logic                          pc_inc,
    input  logic                          mar_load,
    input  logic                          ir_load,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_rvalid,
    output logic [INSTR_BYTES*DATA_W-1:0] command_word,
    output logic                          ir_valid,
    output logic                          busy,
    output logic [ADDR_W-1:0]             pc
);

    localparam int unsigned CNT_W = cnt_width(INSTR_BYTES);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] fetch_base;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              start;
    logic              capture;
    logic              commit;

    // PC and MAR update in every state; MAR samples PC before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= PC_RESET;
            mar <= '0;
        end else begin
            if (mar_load) begin
                mar <= pc;
            end
            if (pc_load) begin
                pc <= pc_load_val;
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(INSTR_BYTES);
            end
        end
    end

    // The fetch base is frozen at ir_load so a later mar_load cannot redirect
    // the bytes still to be read; it also gives mar_load+ir_load the old MAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH_IDLE;
            fetch_base <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                fetch_base <= mar;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        case (state)
            FETCH_IDLE: begin
                if (ir_load) begin
                    start     = 1'b1;
                    state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                mem_rd    = 1'b1;
                mem_addr  = fetch_base + ADDR_W'(cnt);
                state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = last ? FETCH_DONE : FETCH_REQ;
                end
            end
            FETCH_DONE: begin
                commit    = 1'b1;
                state_nxt = FETCH_IDLE;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    assign busy = (state != FETCH_IDLE);

    ir_assembler #(
        .DATA_W      (DATA_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_ir_assembler (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .capture      (capture),
        .commit       (commit),
        .byte_in      (mem_rdata),
        .cnt          (cnt),
        .last         (last),
        .command_word (command_word),
        .ir_valid     (ir_valid)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural PC/MAR model, byte-array program
// memory with configurable response latency, randomized fetch traffic.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        pc_inc;
    logic        mar_load;
    logic        ir_load;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [23:0] command_word;
    logic        ir_valid;
    logic        busy;
    logic [7:0]  pc;

    logic        mem_rd_b;
    logic [7:0]  mem_addr_b;
    logic [23:0] command_word_b;
    logic        ir_valid_b;
    logic        busy_b;
    logic [7:0]  pc_b;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(8), .DATA_W(8), .INSTR_BYTES(3), .PC_RESET(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc_inc(pc_inc), .mar_load(mar_load), .ir_load(ir_load),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .command_word(command_word),
        .ir_valid(ir_valid), .busy(busy), .pc(pc)
    );

    instr_fetch_unit #(
        .ADDR_W(8), .DATA_W(8), .INSTR_BYTES(3), .PC_RESET(8'h10)
    ) dut_b (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc_inc(pc_inc), .mar_load(mar_load), .ir_load(ir_load),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .command_word(command_word_b),
        .ir_valid(ir_valid_b), .busy(busy_b), .pc(pc_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] pc_m;
    logic [7:0] mar_m;

    // Program memory model
    logic [7:0] mem [256];
    int         lat  = 1;
    int         pend = 0;
    int         spur = 0;
    logic [7:0] pend_addr;
    logic [7:0] addr_log [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: notes each request, answers lat edges later.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                addr_log.push_back(mem_addr);
                pend_addr = mem_addr;
                pend      = lat;
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[pend_addr];
                end
            end else if (spur > 0) begin
                spur--;
                mem_rvalid = 1'b1;
                mem_rdata  = 8'hEE;
            end
        end
    end

    // One clock edge; the model follows the architectural PC/MAR rules.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            pc_m  = 8'h00;
            mar_m = 8'h00;
        end else begin
            if (mar_load) mar_m = pc_m;
            if (pc_load) pc_m = pc_load_val;
            else if (pc_inc) pc_m = pc_m + 8'd3;
        end
        #2;
    endtask

    task automatic clear_strobes();
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ir_load  = 1'b0;
    endtask

    // Full fetch from the model's MAR with memory latency l. ir_load is held
    // for `hold` cycles; with noise, extra ir_load pulses and PC traffic occur
    // while the fetch is running.
    task automatic fetch(input int l, input int hold, input bit noise, input string tag);
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp_cw, old_cw;
        int          e, edges;
        bit          got;
        lat = l;
        addr_log.delete();
        b0 = mar_m;
        b1 = b0 + 8'd1;
        b2 = b0 + 8'd2;
        exp_cw = {mem[b2], mem[b1], mem[b0]};
        old_cw = command_word;
        e      = 3 * (1 + l) + 1;
        got    = 1'b0;
        edges  = 0;
        ir_load = 1'b1;
        step();
        for (int k = 0; k < 200; k++) begin
            ir_load = (k < hold - 1) || (noise && k <= e - 2 && ($urandom_range(0, 1) == 1));
            if (noise) begin
                pc_load     = ($urandom_range(0, 3) == 0);
                pc_inc      = ($urandom_range(0, 1) == 1);
                pc_load_val = 8'($urandom);
            end
            step();
            edges = k + 1;
            if (ir_valid) begin
                got = 1'b1;
                break;
            end
            if (k < 3) check_val({tag, "_busy"}, busy, 1);
            if (command_word !== old_cw) check_val({tag, "_cw_hold"}, command_word, old_cw);
        end
        clear_strobes();
        check_val({tag, "_done"}, got, 1);
        check_val({tag, "_latency"}, edges, e);
        check_val({tag, "_cw"}, command_word, exp_cw);
        check_val({tag, "_busy_at_valid"}, busy, 0);
        check_val({tag, "_pc"}, pc, pc_m);
        check_val({tag, "_nreads"}, addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check_val({tag, "_addr0"}, addr_log[0], b0);
            check_val({tag, "_addr1"}, addr_log[1], b1);
            check_val({tag, "_addr2"}, addr_log[2], b2);
        end
        step();
        check_val({tag, "_valid_pulse"}, ir_valid, 0);
        check_val({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [23:0] cw_before;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h03;
        mem[1] = 8'h05;
        mem[2] = 8'h07;
        clear_strobes();
        pc_load_val = 8'h00;
        rst = 1'b1;

        // Reset
        step();
        step();
        rst = 1'b0;
        check_val("rst_pc", pc, 8'h00);
        check_val("rst_cw", command_word, 24'h0);
        check_val("rst_busy", busy, 0);
        check_val("rst_memrd", mem_rd, 0);
        check_val("rst_memaddr", mem_addr, 8'h00);
        check_val("rst_irvalid", ir_valid, 0);
        check_val("rst_b_pc", pc_b, 8'h10);
        check_val("rst_b_state", {busy_b, mem_rd_b, ir_valid_b, mem_addr_b, command_word_b}, 35'h0);

        // Basic fetch at 0
        mar_load = 1'b1;
        step();
        mar_load = 1'b0;
        fetch(1, 2, 1'b0, "basic");
        check_val("basic_word", command_word, 24'h070503);

        // Address wrap
        pc_load = 1'b1;
        pc_load_val = 8'hFE;
        step();
        pc_load = 1'b0;
        mar_load = 1'b1;
        step();
        mar_load = 1'b0;
        fetch(1, 1, 1'b0, "wrap");
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        check_val("wrap_pc", pc, 8'h01);

        // Priority and MAR-before-update
        pc_load = 1'b1;
        pc_inc = 1'b1;
        pc_load_val = 8'h40;
        step();
        check_val("prio_pc", pc, 8'h40);
        pc_inc = 1'b0;
        pc_load_val = 8'h06;
        step();
        pc_load = 1'b0;
        mar_load = 1'b1;
        pc_inc = 1'b1;
        step();
        clear_strobes();
        check_val("mar_pc", pc, 8'h09);
        fetch(1, 1, 1'b0, "mar");
        if (addr_log.size() == 3) check_val("mar_first_addr", addr_log[0], 8'h06);

        // Slow memory with spurious responses while idle
        spur = 2;
        cw_before = command_word;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("spur_idle", busy, 0);
            check_val("spur_noval", ir_valid, 0);
            check_val("spur_cw", command_word, cw_before);
        end
        fetch(4, 1, 1'b1, "slow");

        // Reset in the middle of a fetch, after the second byte
        lat = 1;
        ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_cw", command_word, 24'h0);
        check_val("midrst_pc", pc, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("midrst_noval", ir_valid, 0);
            check_val("midrst_idle", busy, 0);
        end
        fetch(1, 1, 1'b0, "after_rst");
        check_val("after_rst_word", command_word, 24'h070503);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            int ops;
            ops = $urandom_range(1, 5);
            for (int j = 0; j < ops; j++) begin
                pc_load     = ($urandom_range(0, 2) == 0);
                pc_inc      = ($urandom_range(0, 1) == 1);
                mar_load    = ($urandom_range(0, 1) == 1);
                pc_load_val = 8'($urandom);
                step();
                check_val("rnd_pc", pc, pc_m);
            end
            clear_strobes();
            if ($urandom_range(0, 1) == 1) begin
                mar_load = 1'b1;
                step();
                mar_load = 1'b0;
            end
            fetch($urandom_range(1, 4), $urandom_range(1, 2), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
